// File: rtl/gcd_controller_if.sv
// Handshake and datapath-control bundle for the GCD controller.
// slave: controller side; master: requester plus datapath side.
interface gcd_controller_if #(
    parameter int CNT_W = 16
);
    // requester / datapath -> controller
    logic             start;
    logic             done_ack;
    logic             x_gt_y;
    logic             x_lt_y;
    // controller -> datapath / requester
    logic             sel_x;
    logic             sel_y;
    logic             sel_sub;
    logic             ld_x;
    logic             ld_y;
    logic             ld_obeb;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] iter_count;

    modport slave (
        input  start, done_ack, x_gt_y, x_lt_y,
        output sel_x, sel_y, sel_sub,
        output ld_x, ld_y, ld_obeb,
        output busy, done, error, iter_count
    );

    modport master (
        output start, done_ack, x_gt_y, x_lt_y,
        input  sel_x, sel_y, sel_sub,
        input  ld_x, ld_y, ld_obeb,
        input  busy, done, error, iter_count
    );
endinterface

// File: rtl/gcd_controller.sv
// Control FSM for the subtract-and-swap GCD datapath.
// Ports: CLK, reset (async, active-high), bus (gcd_controller_if.slave).
module gcd_controller #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 1000
) (
    input logic             CLK,
    input logic             reset,
    gcd_controller_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CMP  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // Count value at which one more subtraction exhausts the budget.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_ITER - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             in_cmp;
    logic             sub_x;
    logic             sub_y;
    logic             eq;

    // Both flags high cannot happen on a sane datapath; it falls
    // through to the equal branch so the run still terminates.
    assign in_cmp = (state == S_CMP);
    assign sub_x  = in_cmp &&  bus.x_gt_y && !bus.x_lt_y;
    assign sub_y  = in_cmp && !bus.x_gt_y &&  bus.x_lt_y;
    assign eq     = in_cmp && !sub_x && !sub_y;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                end
            end
            S_LOAD: state_nxt = S_CMP;
            S_CMP: begin
                if (sub_x || sub_y) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST)
                        state_nxt = S_ERR;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                end else if (bus.done_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // LOAD captures xi/yi (muxes at 0); CMP steers the subtractor.
    assign bus.ld_x       = (state == S_LOAD) || sub_x;
    assign bus.ld_y       = (state == S_LOAD) || sub_y;
    assign bus.sel_x      = sub_x;
    assign bus.sel_y      = sub_y;
    assign bus.sel_sub    = sub_y;
    assign bus.ld_obeb    = eq;
    assign bus.busy       = (state == S_LOAD) || in_cmp;
    assign bus.done       = (state == S_DONE);
    assign bus.error      = (state == S_ERR);
    assign bus.iter_count = cnt;
endmodule

// File: tb/tb_gcd_controller.sv
// Testbench for gcd_controller with a small datapath and run model.
// Ports: none (top-level bench).
module tb_gcd_controller;
    localparam int CNT_W = 16;
    localparam int MAX   = 8;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    gcd_controller_if #(.CNT_W(CNT_W)) bus ();

    gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    // Datapath: x/y/obeb registers with a shared subtractor.
    logic [15:0] xi = '0;
    logic [15:0] yi = '0;
    logic [15:0] x  = '0;
    logic [15:0] y  = '0;
    logic [15:0] obeb = '0;
    logic [15:0] diff;
    assign diff = bus.sel_sub ? (y - x) : (x - y);
    assign bus.x_gt_y = (x > y);
    assign bus.x_lt_y = (x < y);
    always @(posedge CLK) begin
        if (bus.ld_x) x <= bus.sel_x ? diff : xi;
        if (bus.ld_y) y <= bus.sel_y ? diff : yi;
        if (bus.ld_obeb) obeb <= x;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                     nm, cyc, act, exp);
        end
    endtask

    // ctl order: {busy,done,error,ld_x,ld_y,ld_obeb,sel_x,sel_y,sel_sub}
    typedef struct {
        int         cyc;
        logic [8:0] ctl;
        int         it;
        bit         chk_res;
        int         res;
    } exp_t;

    exp_t q[$];

    localparam logic [8:0] C_IDLE = 9'b000_000_000;
    localparam logic [8:0] C_LOAD = 9'b100_110_000;
    localparam logic [8:0] C_SUBX = 9'b100_100_100;
    localparam logic [8:0] C_SUBY = 9'b100_010_011;
    localparam logic [8:0] C_EQ   = 9'b100_001_000;
    localparam logic [8:0] C_DONE = 9'b010_000_000;
    localparam logic [8:0] C_ERR  = 9'b001_000_000;

    function automatic void push(input int c, input logic [8:0] ctl,
                                 input int it, input bit cr, input int r);
        exp_t e;
        e.cyc = c;
        e.ctl = ctl;
        e.it = it;
        e.chk_res = cr;
        e.res = r;
        q.push_back(e);
    endfunction

    // Run model: start accepted at the end of cycle c; plays out the
    // subtractive Euclid algorithm and queues each cycle's outputs.
    function automatic void model_run(input int c, input int a, input int b,
                                      output int d, output int n,
                                      output bit err, output int res);
        int xa = a;
        int yb = b;
        int k = 0;
        err = 1'b0;
        push(c + 1, C_LOAD, 0, 1'b0, 0);
        while (xa != yb && !err) begin
            if (xa > yb) begin
                push(c + 2 + k, C_SUBX, k, 1'b0, 0);
                xa = xa - yb;
            end else begin
                push(c + 2 + k, C_SUBY, k, 1'b0, 0);
                yb = yb - xa;
            end
            k++;
            if (k == MAX) err = 1'b1;
        end
        n = k;
        if (err) begin
            d = c + 2 + k;
            res = -1;
            push(d, C_ERR, k, 1'b0, 0);
        end else begin
            push(c + 2 + k, C_EQ, k, 1'b0, 0);
            d = c + 3 + k;
            res = xa;
            push(d, C_DONE, k, 1'b1, res);
        end
    endfunction

    logic [8:0] dut_ctl;
    assign dut_ctl = {bus.busy, bus.done, bus.error,
                      bus.ld_x, bus.ld_y, bus.ld_obeb,
                      bus.sel_x, bus.sel_y, bus.sel_sub};

    exp_t ce;
    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            ce = q.pop_front();
            if (ce.cyc < cyc) begin
                chk("skipped_entry", cyc, ce.cyc);
            end else begin
                chk("ctl", int'(dut_ctl), int'(ce.ctl));
                chk("iter_count", int'(bus.iter_count), ce.it);
                if (ce.chk_res) chk("gcd_res", int'(obeb), ce.res);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(input int t);
        int g = 0;
        while (cyc < t && g < 3000) begin
            tick();
            g++;
        end
        if (cyc < t) chk("timeout", cyc, t);
    endtask

    task automatic ack_idle(input int it);
        bus.done_ack = 1'b1;
        push(cyc + 1, C_IDLE, it, 1'b0, 0);
        tick();
        bus.done_ack = 1'b0;
        push(cyc + 1, C_IDLE, it, 1'b0, 0);
        tick();
        tick();
    endtask

    int c, d, n, res;
    bit err;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.done_ack = 1'b0;
        #3;
        chk("rst_ctl", int'(dut_ctl), 0);
        chk("rst_iter", int'(bus.iter_count), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // gcd(12,18): y=6 then x=6, done 5 cycles after start
        c = cyc;
        xi = 16'd12; yi = 16'd18; bus.start = 1'b1;
        model_run(c, 12, 18, d, n, err, res);
        chk("pin_12_18_n", n, 2);
        chk("pin_12_18_res", res, 6);
        chk("pin_12_18_lat", d - c, 5);
        tick();
        bus.start = 1'b0;
        wait_until(d);
        chk("obeb_12_18", int'(obeb), 6);
        ack_idle(2);

        // gcd(7,7): no subtractions, done 3 cycles after start
        c = cyc;
        xi = 16'd7; yi = 16'd7; bus.start = 1'b1;
        model_run(c, 7, 7, d, n, err, res);
        chk("pin_7_7_n", n, 0);
        chk("pin_7_7_lat", d - c, 3);
        tick();
        bus.start = 1'b0;
        wait_until(d);
        ack_idle(0);

        // gcd(1,1000): exceeds the iteration budget
        c = cyc;
        xi = 16'd1; yi = 16'd1000; bus.start = 1'b1;
        model_run(c, 1, 1000, d, n, err, res);
        chk("pin_1_1000_err", int'(err), 1);
        tick();
        bus.start = 1'b0;
        wait_until(d);
        ack_idle(MAX);

        // gcd(0,5): never converges; then restart from ERR with (0,0)
        c = cyc;
        xi = 16'd0; yi = 16'd5; bus.start = 1'b1;
        model_run(c, 0, 5, d, n, err, res);
        chk("pin_0_5_n", n, 8);
        chk("pin_0_5_lat", d - c, 10);
        tick();
        bus.start = 1'b0;
        wait_until(d);
        c = cyc;
        xi = 16'd0; yi = 16'd0; bus.start = 1'b1;
        model_run(c, 0, 0, d, n, err, res);
        chk("pin_0_0_res", res, 0);
        tick();
        bus.start = 1'b0;
        wait_until(d);
        ack_idle(0);

        // start held through gcd(48,18); then start+done_ack in DONE
        c = cyc;
        xi = 16'd48; yi = 16'd18; bus.start = 1'b1;
        model_run(c, 48, 18, d, n, err, res);
        chk("pin_48_18_n", n, 4);
        chk("pin_48_18_res", res, 6);
        wait_until(d);
        c = cyc;
        xi = 16'd9; yi = 16'd6; bus.done_ack = 1'b1;
        model_run(c, 9, 6, d, n, err, res);
        chk("pin_9_6_res", res, 3);
        tick();
        bus.start = 1'b0;
        bus.done_ack = 1'b0;
        wait_until(d);
        ack_idle(2);

        // asynchronous reset in the middle of CMP
        c = cyc;
        xi = 16'd12; yi = 16'd18; bus.start = 1'b1;
        model_run(c, 12, 18, d, n, err, res);
        tick();
        bus.start = 1'b0;
        wait_until(c + 2);
        #1;
        reset = 1'b1;
        q.delete();
        #1;
        chk("midrst_ctl", int'(dut_ctl), 0);
        chk("midrst_iter", int'(bus.iter_count), 0);
        tick();
        chk("midrst_obeb", int'(obeb), 3);
        reset = 1'b0;
        push(cyc + 1, C_IDLE, 0, 1'b0, 0);
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
